finv_pipe: RTL and testbench

- Parametrised, fully pipelined IEEE-754 single-precision reciprocal unit (y ≈ 1/x).
- Uses a table-lookup plus linear-correction datapath: y_mant = 2·b − (m·a)>>23.
- Adds valid/ready flow control with global stall, a sideband tag, correct normalisation when the result mantissa reaches ≥2.0, and special-value handling.
- Sits in the FPU next to the adder/multiplier and feeds the divider path (x/y = x·finv(y)).

---
 rtl/finv_pkg.sv | 36 +++
 rtl/finv_tbl.sv | 31 +++
 rtl/finv_pipe.sv | 168 ++++++++++++++++
 tb/tb_finv_pipe.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/finv_pkg.sv
// Shared types, constants and the reciprocal seed-table generator for the
// finv_pipe reciprocal unit.
package finv_pkg;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] frac;
  } fp32_t;

  typedef enum logic [1:0] {
    CLS_NORMAL,
    CLS_ZERO,
    CLS_INF,
    CLS_NAN
  } finv_cls_e;

  localparam logic [31:0] FP32_QNAN    = 32'h7fc00000;
  localparam logic [7:0]  FP32_EXP_INF = 8'hff;
  localparam int          FINV_EXP_K   = 253;

  // Entry i holds {a, b}: b is the midpoint reciprocal seed of the mantissa
  // interval, a is its square, both scaled so that 2b - (m*a)>>23 ~ 2^24/m.
  function automatic logic [47:0] finv_tbl_entry(input int i, input int tbl_bits);
    logic [63:0] step;
    logic [63:0] den;
    logic [63:0] x0;
    logic [63:0] sq;
    step = 64'd1 << (22 - tbl_bits);
    den  = ((64'd1 << tbl_bits) + 64'(i)) << (22 - tbl_bits);
    x0   = ((64'd1 << 46) / den + (64'd1 << 46) / (den + step)) >> 1;
    sq   = (x0 * x0) >> 24;
    return {sq[23:0], x0[23:0]};
  endfunction

endpackage

// File: rtl/finv_tbl.sv
// Seed ROM for finv_pipe: 2^TBL_BITS x 48-bit {a, b} entries, one-cycle
// registered read that holds its output while en is low.
module finv_tbl
  import finv_pkg::*;
#(
  parameter int TBL_BITS = 10
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic [TBL_BITS-1:0] addr,
  output logic [47:0]         data
);

  localparam int ENTRIES = 1 << TBL_BITS;

  logic [47:0] rom [ENTRIES];

  for (genvar g = 0; g < ENTRIES; g++) begin : g_rom
    assign rom[g] = finv_tbl_entry(g, TBL_BITS);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data <= '0;
    end else if (en) begin
      data <= rom[addr];
    end
  end

endmodule

// File: rtl/finv_pipe.sv
// Three-stage pipelined fp32 reciprocal (table seed + linear correction) with
// valid/ready flow control. Define FINV_STATUS_EN to add the {nv, dz, uf} flags port.
module finv_pipe
  import finv_pkg::*;
#(
  parameter int TBL_BITS = 10,
  parameter int TAG_W    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      x,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      y,
  output logic [TAG_W-1:0] out_tag
`ifdef FINV_STATUS_EN
  ,
  output logic [2:0]       flags
`endif
);

  logic en;

  // A single global enable: the whole pipe freezes only when a result is stuck.
  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  logic             s1_valid;
  fp32_t            s1_x;
  logic [TAG_W-1:0] s1_tag;
  logic [47:0]      tbl_q;
  finv_cls_e        s1_cls;
  logic [24:0]      s1_m;

  finv_tbl #(
    .TBL_BITS (TBL_BITS)
  ) u_tbl (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .addr  (x[22 -: TBL_BITS]),
    .data  (tbl_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_x     <= '0;
      s1_tag   <= '0;
    end else if (en) begin
      s1_valid <= in_valid;
      s1_x     <= x;
      s1_tag   <= in_tag;
    end
  end

  always_comb begin
    s1_cls = CLS_NORMAL;
    if (s1_x.exp == 8'h00) begin
      s1_cls = CLS_ZERO;
    end else if (s1_x.exp == FP32_EXP_INF) begin
      s1_cls = (s1_x.frac == '0) ? CLS_INF : CLS_NAN;
    end
  end

  assign s1_m = {2'b01, s1_x.frac};

  logic               s2_valid;
  logic [48:0]        s2_p;
  logic [24:0]        s2_b2;
  logic signed [9:0]  s2_e;
  logic               s2_sign;
  finv_cls_e          s2_cls;
  logic [TAG_W-1:0]   s2_tag;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_p     <= '0;
      s2_b2    <= '0;
      s2_e     <= '0;
      s2_sign  <= 1'b0;
      s2_cls   <= CLS_NORMAL;
      s2_tag   <= '0;
    end else if (en) begin
      s2_valid <= s1_valid;
      s2_p     <= 49'(s1_m) * 49'(tbl_q[47:24]);
      s2_b2    <= {tbl_q[23:0], 1'b0};
      s2_e     <= 10'(FINV_EXP_K) - 10'(s1_x.exp);
      s2_sign  <= s1_x.sign;
      s2_cls   <= s2_cls_next(s1_cls);
      s2_tag   <= s1_tag;
    end
  end

  function automatic finv_cls_e s2_cls_next(input finv_cls_e c);
    return c;
  endfunction

  logic [48:0]       r;
  logic              n;
  logic signed [9:0] e_out;
  logic [22:0]       frac;
  logic [31:0]       y_next;
  logic [2:0]        status;

  // r is nominally in [2^23, 2^24); reaching 2^24 means the mantissa hit 2.0
  // and the result must be renormalised with a one-step exponent bump.
  always_comb begin
    r      = 49'(s2_b2) - (s2_p >> 23);
    n      = r[24];
    frac   = n ? r[23:1] : r[22:0];
    e_out  = s2_e + 10'(n);
    y_next = {s2_sign, e_out[7:0], frac};
    status = 3'b000;
    case (s2_cls)
      CLS_ZERO: begin
        y_next    = {s2_sign, FP32_EXP_INF, 23'd0};
        status[1] = 1'b1;
      end
      CLS_INF: begin
        y_next = {s2_sign, 31'd0};
      end
      CLS_NAN: begin
        y_next    = FP32_QNAN;
        status[2] = 1'b1;
      end
      default: begin
        if (e_out <= 10'sd0) begin
          y_next    = {s2_sign, 31'd0};
          status[0] = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      y         <= '0;
      out_tag   <= '0;
    end else if (en) begin
      out_valid <= s2_valid;
      y         <= y_next;
      out_tag   <= s2_tag;
    end
  end

`ifdef FINV_STATUS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags <= 3'b000;
    end else if (en) begin
      flags <= status;
    end
  end
`else
  logic unused_status;
  assign unused_status = ^status;
`endif

  logic unused_r_hi;
  assign unused_r_hi = ^r[48:25];

endmodule

// File: tb/tb_finv_pipe.sv
// Scoreboard bench for finv_pipe: directed values, specials, backpressure,
// mid-flight reset and a random sweep across three table sizes.
module tb_finv_pipe;

  localparam int TAG_W = 4;
  localparam int SWEEP_N = 20000;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      x;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      y;
  logic [TAG_W-1:0] out_tag;
  logic             unused_rdy8, out_valid8;
  logic [31:0]      y8;
  logic [TAG_W-1:0] out_tag8;
  logic             unused_rdy12, out_valid12;
  logic [31:0]      y12;
  logic [TAG_W-1:0] out_tag12;
`ifdef FINV_STATUS_EN
  logic [2:0]       flags, unused_flags8, unused_flags12;
`endif

  finv_pipe #(.TBL_BITS(10), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
    .y(y), .out_tag(out_tag)
`ifdef FINV_STATUS_EN
    , .flags(flags)
`endif
  );

  finv_pipe #(.TBL_BITS(8), .TAG_W(TAG_W)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(unused_rdy8),
    .x(x), .in_tag(in_tag), .out_valid(out_valid8), .out_ready(out_ready),
    .y(y8), .out_tag(out_tag8)
`ifdef FINV_STATUS_EN
    , .flags(unused_flags8)
`endif
  );

  finv_pipe #(.TBL_BITS(12), .TAG_W(TAG_W)) dut12 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(unused_rdy12),
    .x(x), .in_tag(in_tag), .out_valid(out_valid12), .out_ready(out_ready),
    .y(y12), .out_tag(out_tag12)
`ifdef FINV_STATUS_EN
    , .flags(unused_flags12)
`endif
  );

  typedef struct {
    logic [31:0]      exp_y;
    logic [TAG_W-1:0] tag;
    logic [2:0]       flg;
    int               tol;
    int               acc_cyc;
    bit               chk_lat;
    bit               sweep;
  } sb_t;

  sb_t  sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   max_err8 = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] obs,
                             input logic [31:0] exp, input int tol);
    longint d;
    n_checks++;
    d = (obs > exp) ? longint'(obs - exp) : longint'(exp - obs);
    if ($isunknown(obs) || d > longint'(tol)) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, want %h (tol %0d ulp)", name, obs, exp, tol);
    end
  endtask

  // Reference reciprocal computed in double precision, rounded to fp32.
  function automatic logic [31:0] ref_recip(input logic [31:0] xv);
    logic [63:0] db;
    logic [31:0] res;
    real         rr;
    db  = {xv[31], {3'b000, xv[30:23]} + 11'd896, xv[22:0], 29'd0};
    rr  = 1.0 / $bitstoreal(db);
    db  = $realtobits(rr);
    res = {db[63], 8'(db[62:52] - 11'd896), db[51:29]};
    if (db[28]) res = res + 32'd1;
    return res;
  endfunction

  task automatic applyStimulus(input logic [31:0] xv, input logic [TAG_W-1:0] tv,
                               input logic [31:0] ev, input logic [2:0] fv,
                               input int tol, input bit lat, input bit swp);
    int  tries;
    sb_t e;
    tries    = 0;
    in_valid = 1'b1;
    x        = xv;
    in_tag   = tv;
    @(negedge clk);
    while (!in_ready && tries < 200) begin
      @(negedge clk);
      tries++;
    end
    if (!in_ready) begin
      checkOutput("in_ready_timeout", 32'(in_ready), 32'd1, 0);
    end else begin
      e.exp_y   = ev;
      e.tag     = tv;
      e.flg     = fv;
      e.tol     = tol;
      e.acc_cyc = cyc;
      e.chk_lat = lat;
      e.sweep   = swp;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic waitDrain(input string name);
    int k;
    k = 0;
    while (sb.size() != 0 && k < 100) begin
      @(posedge clk);
      k++;
    end
    #1;
    checkOutput(name, 32'(sb.size()), 32'd0, 0);
  endtask

  logic             prev_stall = 1'b0;
  logic [31:0]      held_y;
  logic [TAG_W-1:0] held_tag;

  // Output monitor: pops the scoreboard on every transfer and checks that a
  // stalled result stays put.
  always @(negedge clk) begin
    sb_t e;
    int  err;
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        checkOutput("hold_valid", 32'(out_valid), 32'd1, 0);
        checkOutput("hold_y", y, held_y, 0);
        checkOutput("hold_tag", 32'(out_tag), 32'(held_tag), 0);
      end
      if (out_valid && out_ready) begin
        checkOutput("spurious_out", 32'(out_valid), 32'(sb.size() != 0), 0);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          checkOutput(e.sweep ? "y_sweep10" : "y_directed", y, e.exp_y, e.tol);
          checkOutput("out_tag", 32'(out_tag), 32'(e.tag), 0);
`ifdef FINV_STATUS_EN
          checkOutput("flags", 32'(flags), 32'(e.flg), 0);
`endif
          if (e.chk_lat) checkOutput("latency", 32'(cyc - e.acc_cyc), 32'd3, 0);
          if (e.sweep) begin
            checkOutput("y_sweep12", y12, e.exp_y, 4);
            checkOutput("t12_valid", 32'(out_valid12), 32'd1, 0);
            checkOutput("t12_tag", 32'(out_tag12), 32'(e.tag), 0);
            checkOutput("t8_valid", 32'(out_valid8), 32'd1, 0);
            checkOutput("t8_tag", 32'(out_tag8), 32'(e.tag), 0);
            err = (y8 > e.exp_y) ? int'(y8 - e.exp_y) : int'(e.exp_y - y8);
            if (err > max_err8) max_err8 = err;
          end
        end
      end
      prev_stall = out_valid && !out_ready;
      held_y     = y;
      held_tag   = out_tag;
    end
  end

  initial begin
    logic [31:0] xv;
    logic [31:0] bp_x [8];
    bit          bp_done;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    x         = '0;
    in_tag    = '0;
    out_ready = 1'b1;

    #13;
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0, 0);
    checkOutput("rst_y", y, 32'd0, 0);
    checkOutput("rst_out_tag", 32'(out_tag), 32'd0, 0);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] back-to-back directed operands");
    applyStimulus(32'h40400000, 4'h3, 32'h3EAAAAAB, 3'b000, 4, 1, 0);
    applyStimulus(32'h40000000, 4'h5, 32'h3F000000, 3'b000, 4, 1, 0);
    applyStimulus(32'h437f0000, 4'hA, 32'h3B808081, 3'b000, 4, 1, 0);
    waitDrain("drain_directed");

    $display("[TB] special values and normalisation");
    applyStimulus(32'h00000000, 4'h1, 32'h7f800000, 3'b010, 0, 1, 0);
    applyStimulus(32'h80000000, 4'h2, 32'hff800000, 3'b010, 0, 1, 0);
    applyStimulus(32'h7f800000, 4'h3, 32'h00000000, 3'b000, 0, 1, 0);
    applyStimulus(32'h7fc12345, 4'h4, 32'h7fc00000, 3'b100, 0, 1, 0);
    applyStimulus(32'h7f000000, 4'h5, 32'h00000000, 3'b001, 0, 1, 0);
    applyStimulus(32'h3F800000, 4'h6, 32'h3F800000, 3'b000, 4, 1, 0);
    applyStimulus(32'hBF800000, 4'h7, 32'hBF800000, 3'b000, 4, 1, 0);
    waitDrain("drain_special");

    $display("[TB] backpressure stream");
    for (int i = 0; i < 8; i++) begin
      bp_x[i] = {1'b0, 8'(120 + i), 23'($urandom)};
    end
    bp_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          applyStimulus(bp_x[i], 4'(i + 8), ref_recip(bp_x[i]), 3'b000, 4, 0, 0);
        end
        bp_done = 1'b1;
      end
      begin
        int k;
        k = 0;
        while (!(bp_done && sb.size() == 0) && k < 300) begin
          out_ready = (k % 4 == 0) || (k % 4 == 3);
          @(posedge clk);
          #1;
          k++;
        end
        out_ready = 1'b1;
      end
    join
    waitDrain("drain_backpressure");

    $display("[TB] reset with operands in flight");
    applyStimulus(32'h40400000, 4'h1, 32'h3EAAAAAB, 3'b000, 4, 0, 0);
    applyStimulus(32'h40A00000, 4'h2, 32'h3E4CCCCD, 3'b000, 4, 0, 0);
    applyStimulus(32'h41000000, 4'h3, 32'h3E000000, 3'b000, 4, 0, 0);
    #1;
    checkOutput("pre_rst_valid", 32'(out_valid), 32'd1, 0);
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_valid", 32'(out_valid), 32'd0, 0);
    checkOutput("async_rst_y", y, 32'd0, 0);
    checkOutput("async_rst_in_ready", 32'(in_ready), 32'd1, 0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    checkOutput("post_rst_in_ready", 32'(in_ready), 32'd1, 0);
    @(posedge clk);
    #1;
    applyStimulus(32'h40800000, 4'h9, 32'h3E800000, 3'b000, 4, 1, 0);
    waitDrain("drain_after_reset");

    $display("[TB] random sweep over %0d normal operands", SWEEP_N);
    for (int i = 0; i < SWEEP_N; i++) begin
      xv = {1'($urandom), 8'($urandom_range(1, 252)), 23'($urandom)};
      applyStimulus(xv, 4'(i), ref_recip(xv), 3'b000, 4, 1, 1);
    end
    waitDrain("drain_sweep");

    $display("[TB] TBL_BITS=8 maximum sweep error: %0d ulp", max_err8);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
